// File: rtl/debounce_multi_if.sv
// Raw button inputs and cleaned level/pulse outputs
// for the multi-channel debouncer.
interface debounce_multi_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] din_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] rep_o;
  logic [N_CH-1:0] held_o;

  modport master (
    output din_i,
    input  level_o, press_o, release_o,
    input  rep_o, held_o
  );

  modport slave (
    input  din_i,
    output level_o, press_o, release_o,
    output rep_o, held_o
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel debouncer: synchroniser, stability filter,
// press/release pulses and auto-repeat per channel.
module debounce_multi #(
  parameter int N_CH          = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 10,
  parameter int REPEAT_PERIOD = 3
) (
  input logic            CLK,
  input logic            RST,
  debounce_multi_if.slave bus
);
  localparam int M_A = (STABLE_CYCLES > REPEAT_DELAY) ?
                       STABLE_CYCLES : REPEAT_DELAY;
  localparam int M_B = (M_A > REPEAT_PERIOD) ?
                       M_A : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(M_B + 1);
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] STAB_END =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_END =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_END =
    CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rstate_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rls_q, rls_d;
    logic                   rep_q, rep_d;
    logic                   held_q, held_d;
    logic [CNT_W-1:0]       stab_q, stab_d;
    logic [CNT_W-1:0]       rcnt_q, rcnt_d;
    rstate_e                st_q, st_d;
    logic                   rise, fall;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.din_i[i]};
    assign s      = sync_q[SYNC_STAGES-1] ^ INACT;

    always_comb begin
      stab_d  = '0;
      level_d = level_q;
      if (s != level_q) begin
        if (stab_q == STAB_END) begin
          level_d = s;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      rise    = level_d & ~level_q;
      fall    = ~level_d & level_q;
      press_d = rise;
      rls_d   = fall;
    end

    // Release overrides any repeat due in the same cycle
    always_comb begin
      st_d   = st_q;
      rcnt_d = rcnt_q;
      rep_d  = 1'b0;
      held_d = held_q;
      if (REPEAT_DELAY == 0 || fall) begin
        st_d   = IDLE;
        rcnt_d = '0;
        held_d = 1'b0;
      end else begin
        unique case (st_q)
          IDLE: begin
            if (rise) begin
              st_d   = DELAY;
              rcnt_d = '0;
            end
          end
          DELAY: begin
            if (rcnt_q == DLY_END) begin
              rep_d  = 1'b1;
              held_d = 1'b1;
              st_d   = REPEAT;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt_q == PER_END) begin
              rep_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_q  <= {SYNC_STAGES{INACT}};
        level_q <= 1'b0;
        press_q <= 1'b0;
        rls_q   <= 1'b0;
        rep_q   <= 1'b0;
        held_q  <= 1'b0;
        stab_q  <= '0;
        rcnt_q  <= '0;
        st_q    <= IDLE;
      end else begin
        sync_q  <= sync_d;
        level_q <= level_d;
        press_q <= press_d;
        rls_q   <= rls_d;
        rep_q   <= rep_d;
        held_q  <= held_d;
        stab_q  <= stab_d;
        rcnt_q  <= rcnt_d;
        st_q    <= st_d;
      end
    end

    assign bus.level_o[i]   = level_q;
    assign bus.press_o[i]   = press_q;
    assign bus.release_o[i] = rls_q;
    assign bus.rep_o[i]     = rep_q;
    assign bus.held_o[i]    = held_q;
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: event-time
// reference model plus directed latency checks.
module tb_debounce_multi;
  localparam int N  = 2;
  localparam int SY = 2;
  localparam int ST = 4;
  localparam int AL = 1;
  localparam int RD = 10;
  localparam int RP = 3;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rls;
    logic [N-1:0] rep;
    logic [N-1:0] held;
  } obs_t;

  logic CLK;
  logic RST;
  debounce_multi_if #(.N_CH(N)) bus ();

  debounce_multi #(
    .N_CH(N), .SYNC_STAGES(SY), .STABLE_CYCLES(ST),
    .ACTIVE_LOW(AL), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  obs_t sbq[$];

  // model state: pipe of pressed samples, level, run length,
  // and time of the last accepted press
  bit [SY-1:0] m_pipe [N];
  bit          m_lvl  [N];
  int          m_run  [N];
  bit          m_act  [N];
  int          m_pt   [N];

  int p0_edge = -1;
  int p0_cnt = 0;
  int r0_edge = -1;
  int both_edge = -1;
  int rep0_q[$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] d,
                            input logic r);
    obs_t e;
    bit   s, rise, fall, pr;
    int   dd;
    e = '0;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        m_pipe[c] = '0;
        m_lvl[c]  = 1'b0;
        m_run[c]  = 0;
        m_act[c]  = 1'b0;
      end else begin
        rise = 1'b0;
        fall = 1'b0;
        s  = m_pipe[c][SY-1];
        pr = (AL != 0) ? ~d[c] : d[c];
        m_pipe[c] = {m_pipe[c][SY-2:0], pr};
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == ST) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            rise = s;
            fall = !s;
          end
        end else begin
          m_run[c] = 0;
        end
        if (rise) begin
          m_act[c] = 1'b1;
          m_pt[c]  = cyc;
        end
        if (fall) m_act[c] = 1'b0;
        e.level[c] = m_lvl[c];
        e.press[c] = rise;
        e.rls[c]   = fall;
        if (RD > 0 && m_act[c]) begin
          dd = cyc - m_pt[c];
          e.held[c] = (dd >= RD);
          e.rep[c]  = (dd >= RD) && ((dd - RD) % RP == 0);
        end
      end
    end
    sbq.push_back(e);
  endtask

  // inputs change just after edge cyc, sampled at cyc+1
  task automatic tick(input logic [N-1:0] d, input logic r);
    bus.din_i = d;
    RST = r;
    @(posedge CLK);
    cyc++;
    #1;
    model_edge(d, r);
  endtask

  task automatic hold(input logic [N-1:0] d, input int n);
    for (int i = 0; i < n; i++) tick(d, 1'b0);
  endtask

  initial begin : monitor
    obs_t exp, act;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        exp = sbq.pop_front();
        act = {bus.level_o, bus.press_o, bus.release_o,
               bus.rep_o, bus.held_o};
        n_chk++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL scoreboard edge %0d: got %h expected %h",
                   cyc, act, exp);
        end
      end
      if (bus.press_o[0] === 1'b1) begin
        p0_edge = cyc;
        p0_cnt++;
      end
      if (bus.release_o[0] === 1'b1) r0_edge = cyc;
      if (bus.rep_o[0] === 1'b1) rep0_q.push_back(cyc);
      if (bus.press_o === 2'b11) both_edge = cyc;
    end
  end

  initial begin : stim
    int k, j, pc, rc, last_rep;
    int rem [N];
    logic [N-1:0] cur;

    // reset with both buttons held down
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);
    tick(2'b11, 1'b0);
    hold(2'b11, 5);
    chk("reset_level", int'(bus.level_o), 0);
    chk("reset_held", int'(bus.held_o), 0);

    // chatter shorter than the filter window
    pc = p0_cnt;
    tick(2'b10, 1'b0);
    tick(2'b11, 1'b0);
    tick(2'b10, 1'b0);
    tick(2'b10, 1'b0);
    tick(2'b11, 1'b0);
    hold(2'b11, 10);
    chk("chatter_press", p0_cnt, pc);
    chk("chatter_level", int'(bus.level_o[0]), 0);

    // clean press, hold for repeats, then release
    k = cyc;
    p0_edge = -1;
    rep0_q.delete();
    hold(2'b10, 30);
    chk("press_latency", p0_edge, k + 6);
    chk("rep_count", rep0_q.size(), 5);
    if (rep0_q.size() >= 3) begin
      chk("rep_first", rep0_q[0], k + 16);
      chk("rep_second", rep0_q[1], k + 19);
      chk("rep_third", rep0_q[2], k + 22);
    end
    chk("held_on", int'(bus.held_o[0]), 1);
    j = cyc;
    hold(2'b11, 12);
    chk("release_latency", r0_edge, j + 6);
    chk("held_off", int'(bus.held_o[0]), 0);
    last_rep = (rep0_q.size() > 0) ? rep0_q[$] : -1;
    chk("no_rep_after_release", int'(last_rep < j + 6), 1);

    // both channels, then release ch1 only
    k = cyc;
    hold(2'b00, 12);
    chk("both_press", both_edge, k + 6);
    rc = rep0_q.size();
    hold(2'b10, 20);
    chk("ch0_repeats_on", int'(rep0_q.size() > rc + 3), 1);
    chk("ch1_released", int'(bus.level_o), 1);
    hold(2'b11, 15);

    // reset in the middle of a debounce
    k = cyc;
    p0_edge = -1;
    hold(2'b10, 4);
    tick(2'b10, 1'b1);
    hold(2'b10, 12);
    chk("reset_mid_press", p0_edge, k + 11);
    hold(2'b11, 15);

    // random holds of mixed length, occasional reset
    cur = 2'b11;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int t = 0; t < 2500; t++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 4)) :
                   int'($urandom_range(5, 40));
        end
        rem[c]--;
      end
      tick(cur, ($urandom_range(0, 299) == 0));
    end
    hold(2'b11, 3);
    @(negedge CLK);
    #1;
    chk("queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
